// File: rtl/bram_chain_writer.sv
// bram_chain_writer
//   Write-side front end for the coefficient BRAM chain feeding the butterfly
//   units. Coefficients arrive one per handshake, are reduced once modulo Q,
//   packed LANES to a row, and written one row at a time. A frame is NUM_ROWS
//   rows; done_o pulses once the last row has been written.
//
//   Handshake: a coefficient is transferred on a rising edge where
//   coef_valid_i and coef_ready_o are both high. coef_ready_o depends only on
//   state (high in LOAD), never on coef_valid_i. The producer holds coef_i
//   stable while coef_valid_i is high and not yet accepted.
//
// Ports
//   clk_i        : clock, rising edge
//   rst_i        : asynchronous active-high reset
//   start_i      : begin a frame (sampled only in IDLE)
//   coef_i       : incoming coefficient, WIDTH bits
//   coef_valid_i : coef_i valid
//   coef_ready_o : block accepts coef_i this cycle
//   we_o         : row write strobe (registered)
//   waddr_o      : row address (registered, holds outside writes)
//   din_o        : packed row, lane k at [k*WIDTH +: WIDTH]
//   busy_o       : high in LOAD or WRITE
//   done_o       : one-cycle end-of-frame pulse (registered)
//   dbg_state_o  : current FSM state (0 IDLE, 1 LOAD, 2 WRITE, 3 DONE)
module bram_chain_writer #(
  parameter int WIDTH      = 12,
  parameter int LANES      = 16,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_ROWS   = 16,
  parameter int Q          = 3329
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [WIDTH-1:0]       coef_i,
  input  logic                   coef_valid_i,
  output logic                   coef_ready_o,
  output logic                   we_o,
  output logic [ADDR_WIDTH-1:0]  waddr_o,
  output logic [WIDTH*LANES-1:0] din_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [1:0]             dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int                    LANE_W    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0]     LAST_LANE = LANE_W'(LANES - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ROW  = ADDR_WIDTH'(NUM_ROWS - 1);
  localparam logic [WIDTH-1:0]      Q_W       = WIDTH'(Q);

  state_t                   state_q;
  state_t                   state_d;
  logic [LANE_W-1:0]        lane_cnt;
  logic [ADDR_WIDTH-1:0]    row_cnt;
  logic [WIDTH*LANES-1:0]   staging_q;
  logic                     accept;
  logic [WIDTH-1:0]         coef_red;

  assign accept = coef_valid_i && (state_q == S_LOAD);

  // One conditional subtraction is enough: the largest WIDTH-bit input is
  // below 2Q, so the result always lands in [0, Q).
  assign coef_red = (coef_i >= Q_W) ? (coef_i - Q_W) : coef_i;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_LOAD;
      S_LOAD:  if (accept && (lane_cnt == LAST_LANE)) state_d = S_WRITE;
      S_WRITE: state_d = (row_cnt == LAST_ROW) ? S_DONE : S_LOAD;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Lane/row counters and staging row
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lane_cnt  <= '0;
      row_cnt   <= '0;
      staging_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            lane_cnt <= '0;
            row_cnt  <= '0;
          end
        end
        S_LOAD: begin
          if (accept) begin
            staging_q[lane_cnt*WIDTH +: WIDTH] <= coef_red;
            lane_cnt <= (lane_cnt == LAST_LANE) ? '0 : lane_cnt + 1'b1;
          end
        end
        S_WRITE: begin
          // On the last row the counter is left alone; the next start clears it.
          if (row_cnt != LAST_ROW) row_cnt <= row_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Registered BRAM-side outputs, loaded from the next state so they line up
  // with the state register itself.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_o    <= 1'b0;
      waddr_o <= '0;
      done_o  <= 1'b0;
    end else begin
      we_o   <= (state_d == S_WRITE);
      done_o <= (state_d == S_DONE);
      if (state_d == S_WRITE) waddr_o <= row_cnt;
    end
  end

  assign din_o        = staging_q;
  assign coef_ready_o = (state_q == S_LOAD);
  assign busy_o       = (state_q == S_LOAD) || (state_q == S_WRITE);
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_bram_chain_writer.sv
module tb_bram_chain_writer;

  localparam int W  = 12;
  localparam int L  = 16;
  localparam int AW = 5;
  localparam int NR = 16;
  localparam int DW = W * L;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic [W-1:0]  coef_i;
  logic          coef_valid_i;
  logic          coef_ready_o;
  logic          we_o;
  logic [AW-1:0] waddr_o;
  logic [DW-1:0] din_o;
  logic          busy_o;
  logic          done_o;
  logic [1:0]    dbg_state_o;

  bram_chain_writer #(
    .WIDTH(W), .LANES(L), .ADDR_WIDTH(AW), .NUM_ROWS(NR), .Q(3329)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .coef_i(coef_i), .coef_valid_i(coef_valid_i), .coef_ready_o(coef_ready_o),
    .we_o(we_o), .waddr_o(waddr_o), .din_o(din_o),
    .busy_o(busy_o), .done_o(done_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int t0 = 0;
  bit frame_started = 1'b0;

  logic [W-1:0]  coef_mem [0:255];
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] wr_addr_q[$];
  logic [DW-1:0] wr_data_q[$];
  int            wr_cyc_q[$];
  int            done_cyc_q[$];
  int            bad_ready = 0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- monitor (records, does not judge) ----------------
  // Cycle numbering: cycle k is the interval ending at the k-th edge after
  // the edge that sampled start_i.
  always @(negedge clk_i) begin
    if (we_o) begin
      wr_addr_q.push_back(waddr_o);
      wr_data_q.push_back(din_o);
      wr_cyc_q.push_back(cyc - t0 + 1);
      if (coef_ready_o) bad_ready++;
    end
    if (done_o) done_cyc_q.push_back(cyc - t0 + 1);
  end

  // ---------------- model ----------------
  function automatic logic [W-1:0] model_reduce(input logic [W-1:0] v);
    return (v >= 12'd3329) ? v - 12'd3329 : v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_mon();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    done_cyc_q.delete();
    bad_ready = 0;
  endtask

  task automatic start_frame();
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    t0 = cyc;
  endtask

  task automatic send_coef(input logic [W-1:0] v, input int gap);
    coef_valid_i = 1'b0;
    repeat (gap) begin @(posedge clk_i); #1; end
    coef_i = v;
    coef_valid_i = 1'b1;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk_i);
      if (coef_ready_o) begin
        @(posedge clk_i); #1;
        coef_valid_i = 1'b0;
        return;
      end
      @(posedge clk_i); #1;
    end
    coef_valid_i = 1'b0;
    checks++; errors++;
    $display("FAIL send_coef: coef_ready_o not seen within 64 cycles (value %0d)", v);
  endtask

  task automatic wait_done(input int budget);
    for (int t = 0; t < budget; t++) begin
      if (done_cyc_q.size() != 0) return;
      @(posedge clk_i); #1;
    end
    checks++; errors++;
    $display("FAIL wait_done: no done_o within %0d cycles", budget);
  endtask

  task automatic build_expected();
    logic [DW-1:0] row;
    exp_q.delete();
    for (int r = 0; r < NR; r++) begin
      row = '0;
      for (int k = 0; k < L; k++) row[k*W +: W] = model_reduce(coef_mem[r*L + k]);
      exp_q.push_back(row);
    end
  endtask

  task automatic drive_frame(input int max_gap);
    build_expected();
    clear_mon();
    start_frame();
    frame_started = 1'b1;
    for (int i = 0; i < NR * L; i++) send_coef(coef_mem[i], $urandom_range(0, max_gap));
    wait_done(64);
    repeat (3) begin @(posedge clk_i); #1; end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    checks++;
    if ({we_o, done_o, busy_o, coef_ready_o} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: we/done/busy/ready=%b expected 0000", {we_o, done_o, busy_o, coef_ready_o});
    end
    checks++;
    if (waddr_o !== '0) begin errors++; $display("FAIL reset_waddr: got %0d expected 0", waddr_o); end
    checks++;
    if (din_o !== '0) begin errors++; $display("FAIL reset_din: got %h expected 0", din_o); end

    @(posedge clk_i); #1;
    rst_i = 1'b0;
    coef_valid_i = 1'b1;
    coef_i = 12'd5;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      checks++;
      if (coef_ready_o !== 1'b0 || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL idle_ready: ready=%b busy=%b expected 0 0", coef_ready_o, busy_o);
      end
    end
    @(posedge clk_i); #1;
    coef_valid_i = 1'b0;

    // Run partway into a frame so outputs are nonzero, then reset between edges.
    clear_mon();
    start_frame();
    for (int i = 0; i < 40; i++) send_coef(W'(i + 1), 0);
    @(negedge clk_i);
    checks++;
    if (waddr_o !== 5'd1 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: waddr=%0d busy=%b expected 1 1", waddr_o, busy_o);
    end
    checks++;
    if (wr_addr_q.size() != 2) begin
      errors++;
      $display("FAIL pre_reset_writes: got %0d writes expected 2", wr_addr_q.size());
    end
    @(posedge clk_i); #3;
    rst_i = 1'b1;
    #1;
    checks++;
    if ({we_o, done_o, busy_o, coef_ready_o} !== 4'b0000 || dbg_state_o !== 2'd0) begin
      errors++;
      $display("FAIL async_reset_ctrl: we/done/busy/ready=%b state=%0d expected 0000 0",
               {we_o, done_o, busy_o, coef_ready_o}, dbg_state_o);
    end
    checks++;
    if (waddr_o !== '0 || din_o !== '0) begin
      errors++;
      $display("FAIL async_reset_data: waddr=%0d din=%h expected 0 0", waddr_o, din_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic test_full_frame();
    for (int i = 0; i < 256; i++) coef_mem[i] = W'(i);
    drive_frame(0);
    checks++;
    if (wr_addr_q.size() != NR) begin
      errors++; $display("FAIL full_count: got %0d writes expected %0d", wr_addr_q.size(), NR);
    end
    for (int r = 0; r < NR && r < wr_addr_q.size(); r++) begin
      checks++;
      if (wr_addr_q[r] !== AW'(r)) begin
        errors++; $display("FAIL full_addr[%0d]: got %0d expected %0d", r, wr_addr_q[r], r);
      end
      checks++;
      if (wr_data_q[r] !== exp_q[r]) begin
        errors++; $display("FAIL full_data[%0d]: got %h expected %h", r, wr_data_q[r], exp_q[r]);
      end
      checks++;
      if (wr_cyc_q[r] != 17 * (r + 1)) begin
        errors++; $display("FAIL full_cycle[%0d]: got %0d expected %0d", r, wr_cyc_q[r], 17 * (r + 1));
      end
    end
    checks++;
    if (done_cyc_q.size() != 1 || done_cyc_q[0] != 273) begin
      errors++;
      $display("FAIL full_done: pulses=%0d first=%0d expected 1 at 273", done_cyc_q.size(),
               (done_cyc_q.size() != 0) ? done_cyc_q[0] : -1);
    end
    checks++;
    if (bad_ready != 0) begin errors++; $display("FAIL full_ready_in_write: got %0d expected 0", bad_ready); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 256; i++) coef_mem[i] = W'(i);
    drive_frame(5);
    checks++;
    if (wr_addr_q.size() != NR) begin
      errors++; $display("FAIL bp_count: got %0d writes expected %0d", wr_addr_q.size(), NR);
    end
    for (int r = 0; r < NR && r < wr_addr_q.size(); r++) begin
      checks++;
      if (wr_addr_q[r] !== AW'(r) || wr_data_q[r] !== exp_q[r]) begin
        errors++;
        $display("FAIL bp_row[%0d]: addr=%0d data=%h expected addr=%0d data=%h",
                 r, wr_addr_q[r], wr_data_q[r], r, exp_q[r]);
      end
    end
    checks++;
    if (bad_ready != 0) begin errors++; $display("FAIL bp_ready_in_write: got %0d expected 0", bad_ready); end
    checks++;
    if (done_cyc_q.size() != 1) begin
      errors++; $display("FAIL bp_done: got %0d pulses expected 1", done_cyc_q.size());
    end
  endtask

  task automatic test_reduction();
    logic [W-1:0] exp_lane [0:4];
    for (int i = 0; i < 256; i++) coef_mem[i] = W'(i);
    coef_mem[0] = 12'd3328; coef_mem[1] = 12'd3329; coef_mem[2] = 12'd4095;
    coef_mem[3] = 12'd0;    coef_mem[4] = 12'd3330;
    exp_lane[0] = 12'd3328; exp_lane[1] = 12'd0; exp_lane[2] = 12'd766;
    exp_lane[3] = 12'd0;    exp_lane[4] = 12'd1;
    drive_frame(1);
    checks++;
    if (wr_data_q.size() == 0) begin
      errors++; $display("FAIL red_nowrite: got 0 writes expected %0d", NR);
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (wr_data_q[0][k*W +: W] !== exp_lane[k]) begin
          errors++;
          $display("FAIL red_lane[%0d]: got %0d expected %0d", k, wr_data_q[0][k*W +: W], exp_lane[k]);
        end
      end
      checks++;
      if (wr_data_q[0] !== exp_q[0]) begin
        errors++; $display("FAIL red_row0: got %h expected %h", wr_data_q[0], exp_q[0]);
      end
    end
  endtask

  task automatic pulse_start_at(input int k);
    for (int t = 0; t < 4000; t++) begin
      if (frame_started && (cyc - t0 + 1) == k) break;
      @(posedge clk_i); #1;
    end
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic test_start_ignored();
    for (int i = 0; i < 256; i++) coef_mem[i] = W'(255 - i);
    frame_started = 1'b0;
    fork
      drive_frame(0);
      begin
        pulse_start_at(5);
        pulse_start_at(17);
        pulse_start_at(273);
      end
    join
    repeat (4) begin @(posedge clk_i); #1; end
    @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b0 || dbg_state_o !== 2'd0) begin
      errors++; $display("FAIL start_restart: busy=%b state=%0d expected 0 0", busy_o, dbg_state_o);
    end
    checks++;
    if (wr_addr_q.size() != NR) begin
      errors++; $display("FAIL start_count: got %0d writes expected %0d", wr_addr_q.size(), NR);
    end
    for (int r = 0; r < NR && r < wr_addr_q.size(); r++) begin
      checks++;
      if (wr_addr_q[r] !== AW'(r) || wr_data_q[r] !== exp_q[r] || wr_cyc_q[r] != 17 * (r + 1)) begin
        errors++;
        $display("FAIL start_row[%0d]: addr=%0d cyc=%0d data=%h expected addr=%0d cyc=%0d data=%h",
                 r, wr_addr_q[r], wr_cyc_q[r], wr_data_q[r], r, 17 * (r + 1), exp_q[r]);
      end
    end
    checks++;
    if (done_cyc_q.size() != 1 || done_cyc_q[0] != 273) begin
      errors++; $display("FAIL start_done: pulses=%0d expected 1 at 273", done_cyc_q.size());
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset_mid_frame();
    clear_mon();
    start_frame();
    for (int i = 0; i < 5 * L + 7; i++) send_coef(W'(i + 1000), 0);
    #2;
    rst_i = 1'b1;
    #1;
    checks++;
    if (busy_o !== 1'b0 || dbg_state_o !== 2'd0) begin
      errors++; $display("FAIL mid_reset_state: busy=%b state=%0d expected 0 0", busy_o, dbg_state_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (5) begin @(posedge clk_i); #1; end
    checks++;
    if (wr_addr_q.size() != 5 || done_cyc_q.size() != 0) begin
      errors++;
      $display("FAIL mid_reset_writes: writes=%0d done=%0d expected 5 0", wr_addr_q.size(), done_cyc_q.size());
    end
    for (int i = 0; i < 256; i++) coef_mem[i] = W'((i * 37 + 2000) % 4096);
    drive_frame(2);
    checks++;
    if (wr_addr_q.size() != NR || done_cyc_q.size() != 1) begin
      errors++;
      $display("FAIL mid_new_frame: writes=%0d done=%0d expected %0d 1", wr_addr_q.size(), done_cyc_q.size(), NR);
    end
    for (int r = 0; r < NR && r < wr_addr_q.size(); r++) begin
      checks++;
      if (wr_addr_q[r] !== AW'(r) || wr_data_q[r] !== exp_q[r]) begin
        errors++;
        $display("FAIL mid_new_row[%0d]: addr=%0d data=%h expected addr=%0d data=%h",
                 r, wr_addr_q[r], wr_data_q[r], r, exp_q[r]);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst_i        = 1'b1;
    start_i      = 1'b0;
    coef_valid_i = 1'b0;
    coef_i       = '0;
    test_reset();
    test_full_frame();
    test_backpressure();
    test_reduction();
    test_start_ignored();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
    $finish;
  end

endmodule
